toy_wb_arb: RTL and testbench

TOY_WB_ARB -- requirements
Module: toy_wb_arb

---
 rtl/toy_wb_arb.sv | 183 ++++++++++++++++++
 tb/tb_toy_wb_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/toy_wb_arb.sv
// toy_wb_arb -- four-way round-robin writeback arbiter feeding a 2-entry
// in-order FIFO toward the register file.
//
// Requesters: 0=LSU, 1=ALU, 2=MEXT, 3=CSR.
//
// Ports
//   clk              single clock, rising edge
//   rst_n            asynchronous active-low reset
//   wb_req_vld[3:0]  per-requester writeback request
//   wb_req_rdy[3:0]  per-requester grant (one-hot or zero)
//   wb_req_index     4 x 5-bit destination register, requester r at [r*5 +: 5]
//   wb_req_val       4 x REG_WIDTH write data, requester r at [r*REG_WIDTH +: REG_WIDTH]
//   wb_req_inst_idx  4 x INST_IDX_WIDTH instruction index, same packing
//   flush            discards queued writebacks, blocks grants
//   rf_wr_vld/rdy    FIFO head handshake toward register file
//   rf_wr_en         head valid and destination != x0
//   rf_wr_index/val/inst_idx/src  head entry fields (src = winning requester)
//   stat_stall_cnt   cycles with a request but no grant (saturating)
//
// Build option: define TOY_WB_ARB_STAT_EN to build the stall counter;
// otherwise stat_stall_cnt is tied to zero.
//
// REG_WIDTH / INST_IDX_WIDTH defaults mirror the toy_pack values.

module toy_wb_arb #(
   parameter int REG_WIDTH      = 32,
   parameter int INST_IDX_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [3:0]                    wb_req_vld,
   output logic [3:0]                    wb_req_rdy,
   input  logic [4*5-1:0]                wb_req_index,
   input  logic [4*REG_WIDTH-1:0]        wb_req_val,
   input  logic [4*INST_IDX_WIDTH-1:0]   wb_req_inst_idx,
   input  logic                          flush,
   output logic                          rf_wr_vld,
   input  logic                          rf_wr_rdy,
   output logic                          rf_wr_en,
   output logic [4:0]                    rf_wr_index,
   output logic [REG_WIDTH-1:0]          rf_wr_val,
   output logic [INST_IDX_WIDTH-1:0]     rf_wr_inst_idx,
   output logic [1:0]                    rf_wr_src,
   output logic [15:0]                   stat_stall_cnt
);

   localparam int NREQ  = 4;
   localparam int DEPTH = 2;

   logic [1:0]                rr_ptr_q, rr_ptr_d;
   logic [1:0]                cnt_q, cnt_d;
   logic                      rd_ptr_q, rd_ptr_d;
   logic                      wr_ptr_q, wr_ptr_d;

   logic [4:0]                ent_index_q [DEPTH];
   logic [4:0]                ent_index_d [DEPTH];
   logic [REG_WIDTH-1:0]      ent_val_q   [DEPTH];
   logic [REG_WIDTH-1:0]      ent_val_d   [DEPTH];
   logic [INST_IDX_WIDTH-1:0] ent_inst_q  [DEPTH];
   logic [INST_IDX_WIDTH-1:0] ent_inst_d  [DEPTH];
   logic [1:0]                ent_src_q   [DEPTH];
   logic [1:0]                ent_src_d   [DEPTH];

   logic [1:0] cand;
   logic [1:0] winner;
   logic       winner_found;
   logic       full;
   logic       pop;
   logic       can_push;
   logic       grant;

   // Round-robin search from rr_ptr, wrapping 3 -> 0.
   always_comb begin
      cand         = '0;
      winner       = '0;
      winner_found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         cand = rr_ptr_q + 2'(i);
         if (!winner_found && wb_req_vld[cand]) begin
            winner_found = 1'b1;
            winner       = cand;
         end
      end
   end

   assign rf_wr_vld = (cnt_q != 2'd0);
   assign full      = (cnt_q == 2'(DEPTH));
   assign pop       = rf_wr_vld & rf_wr_rdy;
   // A full FIFO can still accept when the head leaves in the same cycle.
   // rst_n gates the grant so nothing is handed out while reset is held.
   assign can_push  = rst_n & ~flush & (~full | pop);
   assign grant     = winner_found & can_push;
   assign wb_req_rdy = grant ? (4'b0001 << winner) : 4'b0000;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      ent_index_d = ent_index_q;
      ent_val_d   = ent_val_q;
      ent_inst_d  = ent_inst_q;
      ent_src_d   = ent_src_q;

      if (grant) begin
         rr_ptr_d              = winner + 2'd1;
         ent_index_d[wr_ptr_q] = wb_req_index[int'(winner)*5 +: 5];
         ent_val_d[wr_ptr_q]   = wb_req_val[int'(winner)*REG_WIDTH +: REG_WIDTH];
         ent_inst_d[wr_ptr_q]  = wb_req_inst_idx[int'(winner)*INST_IDX_WIDTH +: INST_IDX_WIDTH];
         ent_src_d[wr_ptr_q]   = winner;
      end

      if (flush) begin
         // A pop in this cycle still completes; the queue is simply emptied.
         cnt_d    = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         rd_ptr_d = rd_ptr_q ^ pop;
         wr_ptr_d = wr_ptr_q ^ grant;
         case ({grant, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_index_q[i] <= '0;
            ent_val_q[i]   <= '0;
            ent_inst_q[i]  <= '0;
            ent_src_q[i]   <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         ent_index_q <= ent_index_d;
         ent_val_q   <= ent_val_d;
         ent_inst_q  <= ent_inst_d;
         ent_src_q   <= ent_src_d;
      end
   end

   assign rf_wr_index    = ent_index_q[rd_ptr_q];
   assign rf_wr_val      = ent_val_q[rd_ptr_q];
   assign rf_wr_inst_idx = ent_inst_q[rd_ptr_q];
   assign rf_wr_src      = ent_src_q[rd_ptr_q];
   // x0 writes travel through the queue but never enable the write port.
   assign rf_wr_en       = rf_wr_vld & (rf_wr_index != 5'd0);

`ifdef TOY_WB_ARB_STAT_EN
   logic [15:0] stat_q, stat_d;

   always_comb begin
      stat_d = stat_q;
      if ((|wb_req_vld) && !grant && (stat_q != 16'hFFFF)) begin
         stat_d = stat_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign stat_stall_cnt = stat_q;
`else
   assign stat_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_toy_wb_arb.sv
module tb_toy_wb_arb;

   localparam int RW = 32;
   localparam int IW = 8;
`ifdef TOY_WB_ARB_STAT_EN
   localparam logic [15:0] STAT_BP = 16'd2;
`else
   localparam logic [15:0] STAT_BP = 16'd0;
`endif

   logic            clk;
   logic            rst_n;
   logic [3:0]      wb_req_vld;
   logic [3:0]      wb_req_rdy;
   logic [19:0]     wb_req_index;
   logic [4*RW-1:0] wb_req_val;
   logic [4*IW-1:0] wb_req_inst_idx;
   logic            flush;
   logic            rf_wr_vld;
   logic            rf_wr_rdy;
   logic            rf_wr_en;
   logic [4:0]      rf_wr_index;
   logic [RW-1:0]   rf_wr_val;
   logic [IW-1:0]   rf_wr_inst_idx;
   logic [1:0]      rf_wr_src;
   logic [15:0]     stat_stall_cnt;

   int checks = 0;
   int errors = 0;

   toy_wb_arb #(.REG_WIDTH(RW), .INST_IDX_WIDTH(IW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .wb_req_vld      (wb_req_vld),
      .wb_req_rdy      (wb_req_rdy),
      .wb_req_index    (wb_req_index),
      .wb_req_val      (wb_req_val),
      .wb_req_inst_idx (wb_req_inst_idx),
      .flush           (flush),
      .rf_wr_vld       (rf_wr_vld),
      .rf_wr_rdy       (rf_wr_rdy),
      .rf_wr_en        (rf_wr_en),
      .rf_wr_index     (rf_wr_index),
      .rf_wr_val       (rf_wr_val),
      .rf_wr_inst_idx  (rf_wr_inst_idx),
      .rf_wr_src       (rf_wr_src),
      .stat_stall_cnt  (stat_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [4:0] idx, input logic [RW-1:0] val,
                          input logic [IW-1:0] inst);
      wb_req_index[r*5 +: 5]     = idx;
      wb_req_val[r*RW +: RW]     = val;
      wb_req_inst_idx[r*IW +: IW] = inst;
   endtask

   initial begin
      rst_n      = 1'b0;
      wb_req_vld = 4'hF;
      flush      = 1'b0;
      rf_wr_rdy  = 1'b1;
      wb_req_index = '0;
      wb_req_val   = '0;
      wb_req_inst_idx = '0;
      for (int r = 0; r < 4; r++) set_req(r, 5'(r + 1), 32'h1000_0000 + RW'(r), 8'h10 + IW'(r));

      // reset state, with all requests asserted
      #3;
      chk("rst_rdy",   64'(wb_req_rdy), 64'h0);
      chk("rst_vld",   64'(rf_wr_vld), 64'h0);
      chk("rst_en",    64'(rf_wr_en), 64'h0);
      chk("rst_index", 64'(rf_wr_index), 64'h0);
      chk("rst_val",   64'(rf_wr_val), 64'h0);
      chk("rst_inst",  64'(rf_wr_inst_idx), 64'h0);
      chk("rst_src",   64'(rf_wr_src), 64'h0);
      chk("rst_stat",  64'(stat_stall_cnt), 64'h0);
      step();
      rst_n = 1'b1;

      // round robin: grants 0,1,2,3,0; head src one cycle behind
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("rr_grant", 64'(wb_req_rdy), 64'(4'b0001 << (k % 4)));
         if (k > 0) begin
            chk("rr_hvld",  64'(rf_wr_vld), 64'h1);
            chk("rr_src",   64'(rf_wr_src), 64'((k - 1) % 4));
            chk("rr_val",   64'(rf_wr_val), 64'(32'h1000_0000 + 32'((k - 1) % 4)));
            chk("rr_index", 64'(rf_wr_index), 64'((k - 1) % 4 + 1));
            chk("rr_inst",  64'(rf_wr_inst_idx), 64'(8'h10 + 8'((k - 1) % 4)));
            chk("rr_en",    64'(rf_wr_en), 64'h1);
         end
         step();
      end

      // backpressure: ALU only, register file stalled
      rst_n = 1'b0;
      wb_req_vld = 4'b0000;
      #2;
      step();
      rst_n = 1'b1;
      wb_req_vld = 4'b0010;
      rf_wr_rdy = 1'b0;
      set_req(1, 5'd2, 32'hA1, 8'h21);
      #1 chk("bp_g0", 64'(wb_req_rdy), 64'b0010);
      step();
      set_req(1, 5'd2, 32'hA2, 8'h22);
      #1 chk("bp_g1", 64'(wb_req_rdy), 64'b0010);
      chk("bp_head1", 64'(rf_wr_val), 64'hA1);
      step();
      #1 chk("bp_full2", 64'(wb_req_rdy), 64'b0000);
      chk("bp_head2", 64'(rf_wr_val), 64'hA1);
      step();
      #1 chk("bp_full3", 64'(wb_req_rdy), 64'b0000);
      chk("bp_head3", 64'(rf_wr_val), 64'hA1);
      chk("bp_hinst", 64'(rf_wr_inst_idx), 64'h21);
      step();
      chk("bp_stat", 64'(stat_stall_cnt), 64'(STAT_BP));

      // full with pop: MEXT granted while head drains
      wb_req_vld = 4'b0100;
      rf_wr_rdy = 1'b1;
      set_req(2, 5'd7, 32'h4D1, 8'h31);
      #1 chk("fp_grant", 64'(wb_req_rdy), 64'b0100);
      step();
      rf_wr_rdy = 1'b0;
      #1 chk("fp_still_full", 64'(wb_req_rdy), 64'b0000);
      chk("fp_head_a2", 64'(rf_wr_val), 64'hA2);
      wb_req_vld = 4'b0000;
      rf_wr_rdy = 1'b1;
      step();
      chk("fp_head_m1", 64'(rf_wr_val), 64'h4D1);
      chk("fp_src", 64'(rf_wr_src), 64'h2);
      chk("fp_index", 64'(rf_wr_index), 64'h7);
      step();
      chk("fp_empty", 64'(rf_wr_vld), 64'h0);

      // x0 write from CSR
      set_req(3, 5'd0, 32'hDEADBEEF, 8'h41);
      wb_req_vld = 4'b1000;
      #1 chk("x0_grant", 64'(wb_req_rdy), 64'b1000);
      step();
      wb_req_vld = 4'b0000;
      #1 chk("x0_vld", 64'(rf_wr_vld), 64'h1);
      chk("x0_en", 64'(rf_wr_en), 64'h0);
      chk("x0_val", 64'(rf_wr_val), 64'hDEADBEEF);
      chk("x0_src", 64'(rf_wr_src), 64'h3);
      step();
      chk("x0_popped", 64'(rf_wr_vld), 64'h0);

      // flush with two entries queued
      rf_wr_rdy = 1'b0;
      wb_req_vld = 4'b0010;
      set_req(1, 5'd9, 32'hF1, 8'h51);
      #1 chk("fl_g0", 64'(wb_req_rdy), 64'b0010);
      step();
      set_req(1, 5'd9, 32'hF2, 8'h52);
      #1 chk("fl_g1", 64'(wb_req_rdy), 64'b0010);
      step();
      flush = 1'b1;
      wb_req_vld = 4'b0001;
      #1 chk("fl_nogrant", 64'(wb_req_rdy), 64'b0000);
      chk("fl_hvld", 64'(rf_wr_vld), 64'h1);
      step();
      flush = 1'b0;
      wb_req_vld = 4'hF;
      rf_wr_rdy = 1'b1;
      #1 chk("fl_empty", 64'(rf_wr_vld), 64'h0);
      chk("fl_rrptr", 64'(wb_req_rdy), 64'b0100);
      step();

      // reset mid-stream
      wb_req_vld = 4'hF;
      rf_wr_rdy = 1'b0;
      #1 chk("mr_hvld", 64'(rf_wr_vld), 64'h1);
      chk("mr_src", 64'(rf_wr_src), 64'h2);
      #2 rst_n = 1'b0;
      #1 chk("mr_vld0", 64'(rf_wr_vld), 64'h0);
      chk("mr_index0", 64'(rf_wr_index), 64'h0);
      chk("mr_val0", 64'(rf_wr_val), 64'h0);
      chk("mr_rdy0", 64'(wb_req_rdy), 64'h0);
      step();
      step();
      rst_n = 1'b1;
      rf_wr_rdy = 1'b1;
      #1 chk("mr_rrptr0", 64'(wb_req_rdy), 64'b0001);
      chk("mr_stat0", 64'(stat_stall_cnt), 64'h0);
      chk("mr_empty", 64'(rf_wr_vld), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
